opfetch_seq: RTL and testbench
==============================

OPFETCH_SEQ -- requirements
Module: opfetch_seq

Interface
REQ-001 Parameter DATA_W, default 16: register data width.
REQ-002 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1: reset, synchronous and active-high.
REQ-004 Port instr_valid  input  1: upstream instruction word present.
REQ-005 Port instr  input  16: instruction; [15:12] opcode, [11:8] field R1, [7:4] field R2, [3:0] field R3, [1:0] func.
REQ-006 Port instr_ready  output  1: block can accept an instruction.
REQ-007 Ports ReadRegSrc1, ReadRegSrc2, ReadRegSrc3  input  1 each: operand address selects from the register-source select decoder, valid with instr.
REQ-008 Port rf_raddr  output  4: register file read address.
REQ-009 Port rf_re  output  1: register file read enable.
REQ-010 Port rf_rdata  input  DATA_W: register file read data, valid one cycle after rf_raddr/rf_re.
REQ-011 Ports opA, opB, opC  output  DATA_W each: fetched operands.
REQ-012 Ports op_opcode  output  4, op_func  output  2: opcode/func of the instruction being presented.
REQ-013 Port op_valid  output  1: operands and opcode valid; op_ready  input  1: downstream accepts.

Function
REQ-014 FSM states: IDLE, ISSUE_A, ISSUE_B, ISSUE_C, CAP_C, VALID.
REQ-015 IDLE: instr_ready=1, rf_re=0, op_valid=0; on instr_valid=1, latch instr and the three selects, go to ISSUE_A.
- REQ-016 Address select: addrA = ReadRegSrc1 ? R1 : R2; addrB = ReadRegSrc2 ? R1 : R3; addrC = ReadRegSrc3 ? R2 : R1 (latched selects).
REQ-017 ISSUE_A: rf_raddr=addrA, rf_re=1; next ISSUE_B.
REQ-018 ISSUE_B: rf_raddr=addrB, rf_re=1, opA<=rf_rdata; next ISSUE_C.
REQ-019 ISSUE_C: rf_raddr=addrC, rf_re=1, opB<=rf_rdata; next CAP_C.
REQ-020 CAP_C: rf_re=0, opC<=rf_rdata; next VALID.
REQ-021 VALID: op_valid=1; opA/opB/opC/op_opcode/op_func held stable while op_ready=0; on op_ready=1 go to IDLE.
REQ-022 Latency: op_valid rises exactly 4 cycles after the accepting edge; next accept no earlier than 1 cycle after the op_ready handshake (6-cycle minimum per instruction).
REQ-023 instr_ready=0 in every state except IDLE; instr_valid outside IDLE is ignored and does not alter latched state.
REQ-024 rf_raddr=0 whenever rf_re=0.
REQ-025 Selects and address fields are sampled only at accept; later changes on instr/ReadRegSrc* have no effect on the in-flight fetch.
REQ-026 Register index 0 and identical addresses across operands are read normally, with no special-casing.

Reset
REQ-027 reset=1 at a rising edge forces IDLE regardless of state, including mid-fetch and in VALID with op_ready=0; the in-flight instruction is discarded.
REQ-028 Reset values: op_valid=0, rf_re=0, rf_raddr=0, opA=opB=opC=0, op_opcode=0, op_func=0, latched selects=0; instr_ready=1 in the first cycle after reset is released.

Configuration
REQ-029 Macro OPFETCH_WB_BYPASS_EN: when defined, add inputs wb_en (1), wb_addr (4) and wb_data (DATA_W); in each capture cycle (ISSUE_B, ISSUE_C, CAP_C), if wb_en=1 and wb_addr equals the address issued in the previous cycle, the operand register captures wb_data instead of rf_rdata.
REQ-030 When OPFETCH_WB_BYPASS_EN is undefined, the wb_* ports are absent and operands always capture rf_rdata.

Verification
REQ-031 Model RF with r[n]=0x1000+n, instr=0x8123, selects 0/0/0, op_ready=1 -> rf_raddr sequence 2,3,1; opA=0x1002, opB=0x1003, opC=0x1001, op_opcode=8, op_func=3, op_valid 4 cycles after accept.
REQ-032 instr=0x1456, selects 1/1/1 -> addresses 4,4,5; opA=opB=0x1004, opC=0x1005.
REQ-033 op_ready held 0 for 10 cycles in VALID, with instr_valid pulsed -> outputs stable, instr_ready=0, no new accept; op_ready=1 -> IDLE the next cycle.
REQ-034 reset asserted in ISSUE_C -> next cycle IDLE, op_valid=0, rf_re=0, operands=0; a subsequent instruction fetches correctly.
REQ-035 With OPFETCH_WB_BYPASS_EN defined: instr=0x8123, wb_en=1, wb_addr=3, wb_data=0xBEEF during ISSUE_C -> opB=0xBEEF, opA=0x1002, opC=0x1001.
REQ-036 Back-to-back instr_valid held 1 with op_ready=1 -> one accept per 6 cycles, no lost or duplicated instruction.

Source files
------------

// File: rtl/opfetch_seq.sv
// Operand fetch sequencer: reads up to three register operands over a single RF read port.
// Optional write-back bypass on capture cycles is enabled by defining OPFETCH_WB_BYPASS_EN.
module opfetch_seq #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    input  logic              ReadRegSrc1,
    input  logic              ReadRegSrc2,
    input  logic              ReadRegSrc3,
    output logic [3:0]        rf_raddr,
    output logic              rf_re,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DATA_W-1:0] opA,
    output logic [DATA_W-1:0] opB,
    output logic [DATA_W-1:0] opC,
    output logic [3:0]        op_opcode,
    output logic [1:0]        op_func,
    output logic              op_valid,
`ifdef OPFETCH_WB_BYPASS_EN
    input  logic              wb_en,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
`endif
    input  logic              op_ready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_A = 3'd1,
        ISSUE_B = 3'd2,
        ISSUE_C = 3'd3,
        CAP_C   = 3'd4,
        VALID   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       ins_q, ins_d;
    logic [2:0]        sel_q, sel_d;
    logic              instr_ready_d, rf_re_d, op_valid_d;
    logic [3:0]        rf_raddr_d;
    logic [3:0]        addr_a, addr_b, addr_c;
    logic [DATA_W-1:0] opa_d, opb_d, opc_d, cap_data;
    logic [3:0]        opcode_d;
    logic [1:0]        func_d;

`ifdef OPFETCH_WB_BYPASS_EN
    // Address issued in the previous cycle; its data is what arrives on rf_rdata now.
    logic [3:0] prev_addr_q;

    always_ff @(posedge clk) begin
        if (reset) prev_addr_q <= 4'h0;
        else       prev_addr_q <= rf_raddr;
    end

    assign cap_data = (wb_en && (wb_addr == prev_addr_q)) ? wb_data : rf_rdata;
`else
    assign cap_data = rf_rdata;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ins_q       <= 16'h0;
            sel_q       <= 3'b000;
            instr_ready <= 1'b1;
            rf_re       <= 1'b0;
            rf_raddr    <= 4'h0;
            op_valid    <= 1'b0;
            opA         <= '0;
            opB         <= '0;
            opC         <= '0;
            op_opcode   <= 4'h0;
            op_func     <= 2'b00;
        end else begin
            state_q     <= state_d;
            ins_q       <= ins_d;
            sel_q       <= sel_d;
            instr_ready <= instr_ready_d;
            rf_re       <= rf_re_d;
            rf_raddr    <= rf_raddr_d;
            op_valid    <= op_valid_d;
            opA         <= opa_d;
            opB         <= opb_d;
            opC         <= opc_d;
            op_opcode   <= opcode_d;
            op_func     <= func_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ins_d         = ins_q;
        sel_d         = sel_q;
        opa_d         = opA;
        opb_d         = opB;
        opc_d         = opC;
        opcode_d      = op_opcode;
        func_d        = op_func;
        instr_ready_d = 1'b0;
        rf_re_d       = 1'b0;
        rf_raddr_d    = 4'h0;
        op_valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    ins_d   = instr;
                    sel_d   = {ReadRegSrc3, ReadRegSrc2, ReadRegSrc1};
                    state_d = ISSUE_A;
                end
            end
            ISSUE_A: state_d = ISSUE_B;
            ISSUE_B: begin
                opa_d   = cap_data;
                state_d = ISSUE_C;
            end
            ISSUE_C: begin
                opb_d   = cap_data;
                state_d = CAP_C;
            end
            CAP_C: begin
                opc_d    = cap_data;
                opcode_d = ins_q[15:12];
                func_d   = ins_q[1:0];
                state_d  = VALID;
            end
            VALID: begin
                if (op_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        addr_a = sel_d[0] ? ins_d[11:8] : ins_d[7:4];
        addr_b = sel_d[1] ? ins_d[11:8] : ins_d[3:0];
        addr_c = sel_d[2] ? ins_d[7:4]  : ins_d[11:8];

        case (state_d)
            IDLE:    instr_ready_d = 1'b1;
            ISSUE_A: begin rf_re_d = 1'b1; rf_raddr_d = addr_a; end
            ISSUE_B: begin rf_re_d = 1'b1; rf_raddr_d = addr_b; end
            ISSUE_C: begin rf_re_d = 1'b1; rf_raddr_d = addr_c; end
            VALID:   op_valid_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_opfetch_seq.sv
// Directed self-checking bench for opfetch_seq with a model register file r[n] = 0x1000 + n.
// Define OPFETCH_WB_BYPASS_EN for both files to exercise the write-back bypass.
module tb_opfetch_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        ReadRegSrc1, ReadRegSrc2, ReadRegSrc3;
    logic [3:0]  rf_raddr;
    logic        rf_re;
    logic [15:0] rf_rdata;
    logic [15:0] opA, opB, opC;
    logic [3:0]  op_opcode;
    logic [1:0]  op_func;
    logic        op_valid;
    logic        op_ready;
`ifdef OPFETCH_WB_BYPASS_EN
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    opfetch_seq #(.DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .ReadRegSrc1(ReadRegSrc1), .ReadRegSrc2(ReadRegSrc2), .ReadRegSrc3(ReadRegSrc3),
        .rf_raddr(rf_raddr), .rf_re(rf_re), .rf_rdata(rf_rdata),
        .opA(opA), .opB(opB), .opC(opC),
        .op_opcode(op_opcode), .op_func(op_func), .op_valid(op_valid),
`ifdef OPFETCH_WB_BYPASS_EN
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
`endif
        .op_ready(op_ready)
    );

    // Register file model: one-cycle read latency, poison when not enabled.
    always @(posedge clk) rf_rdata <= rf_re ? (16'h1000 + {12'h000, rf_raddr}) : 16'hDEAD;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; instr = 16'h0; op_ready = 1'b0;
        {ReadRegSrc3, ReadRegSrc2, ReadRegSrc1} = 3'b000;
`ifdef OPFETCH_WB_BYPASS_EN
        wb_en = 1'b0; wb_addr = 4'h0; wb_data = 16'h0;
`endif
        step(); step();
        reset = 1'b0;
        checks++;
        if ({instr_ready, op_valid, rf_re, rf_raddr} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/val/re/addr=%b/%b/%b/%h want 1/0/0/0", instr_ready, op_valid, rf_re, rf_raddr);
        end
        checks++;
        if ({opA, opB, opC, op_opcode, op_func} !== 54'h0) begin
            errors++;
            $display("FAIL reset_data: opA=%h opB=%h opC=%h opc=%h func=%h want all 0", opA, opB, opC, op_opcode, op_func);
        end
    endtask

    // One full instruction: expected addresses are supplied, operand values follow the RF model.
    task automatic do_fetch(input string name, input logic [15:0] ins, input logic [2:0] sel,
                            input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] ec,
                            input int hold);
        logic [15:0] xa, xb, xc;
        xa = 16'h1000 + {12'h000, ea};
        xb = 16'h1000 + {12'h000, eb};
        xc = 16'h1000 + {12'h000, ec};
        instr = ins; {ReadRegSrc3, ReadRegSrc2, ReadRegSrc1} = sel;
        instr_valid = 1'b1; op_ready = 1'b0;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL %s idle_ready: got %b want 1", name, instr_ready);
        end
        step();
        // Disturb the inputs after accept; the in-flight fetch must not notice.
        instr_valid = 1'b0; instr = 16'hFFFF; {ReadRegSrc3, ReadRegSrc2, ReadRegSrc1} = ~sel;
        checks++;
        if ({instr_ready, rf_re, rf_raddr} !== {1'b0, 1'b1, ea}) begin
            errors++; $display("FAIL %s issue_a: rdy/re/addr=%b/%b/%h want 0/1/%h", name, instr_ready, rf_re, rf_raddr, ea);
        end
        step();
        checks++;
        if ({rf_re, rf_raddr} !== {1'b1, eb}) begin
            errors++; $display("FAIL %s issue_b: re/addr=%b/%h want 1/%h", name, rf_re, rf_raddr, eb);
        end
        step();
        checks++;
        if ({rf_re, rf_raddr} !== {1'b1, ec}) begin
            errors++; $display("FAIL %s issue_c: re/addr=%b/%h want 1/%h", name, rf_re, rf_raddr, ec);
        end
        step();
        checks++;
        if ({rf_re, rf_raddr, op_valid} !== {1'b0, 4'h0, 1'b0}) begin
            errors++; $display("FAIL %s cap_c: re/addr/val=%b/%h/%b want 0/0/0", name, rf_re, rf_raddr, op_valid);
        end
        step();
        checks++;
        if (op_valid !== 1'b1) begin
            errors++; $display("FAIL %s latency: op_valid=%b want 1", name, op_valid);
        end
        checks++;
        if ({opA, opB, opC, op_opcode, op_func} !== {xa, xb, xc, ins[15:12], ins[1:0]}) begin
            errors++;
            $display("FAIL %s operands: A=%h B=%h C=%h opc=%h func=%h want %h %h %h %h %h",
                     name, opA, opB, opC, op_opcode, op_func, xa, xb, xc, ins[15:12], ins[1:0]);
        end
        for (int i = 0; i < hold; i++) begin
            instr_valid = i[0]; instr = 16'h0F0F;
            step();
            checks++;
            if ({op_valid, instr_ready, opA, opB, opC, op_opcode, op_func} !==
                {1'b1, 1'b0, xa, xb, xc, ins[15:12], ins[1:0]}) begin
                errors++;
                $display("FAIL %s hold%0d: val=%b rdy=%b A=%h B=%h C=%h opc=%h want 1 0 %h %h %h %h",
                         name, i, op_valid, instr_ready, opA, opB, opC, op_opcode, xa, xb, xc, ins[15:12]);
            end
        end
        instr_valid = 1'b0;
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        checks++;
        if ({instr_ready, op_valid, rf_re} !== {1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL %s to_idle: rdy/val/re=%b/%b/%b want 1/0/0", name, instr_ready, op_valid, rf_re);
        end
    endtask

    task automatic test_fetch();
        do_fetch("basic",  16'h8123, 3'b000, 4'h2, 4'h3, 4'h1, 0);
        do_fetch("allsel", 16'h1456, 3'b111, 4'h4, 4'h4, 4'h5, 0);
        do_fetch("zero",   16'h0000, 3'b000, 4'h0, 4'h0, 4'h0, 0);
        do_fetch("mixsel", 16'hA9C7, 3'b101, 4'h9, 4'h7, 4'hC, 0);
    endtask

    task automatic test_stall();
        do_fetch("stall", 16'h5ABE, 3'b010, 4'hB, 4'hA, 4'hA, 10);
    endtask

    task automatic test_reset_midfetch();
        instr = 16'h8123; {ReadRegSrc3, ReadRegSrc2, ReadRegSrc1} = 3'b000;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({instr_ready, op_valid, rf_re, rf_raddr} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL midreset_ctrl: rdy/val/re/addr=%b/%b/%b/%h want 1/0/0/0", instr_ready, op_valid, rf_re, rf_raddr);
        end
        checks++;
        if ({opA, opB, opC} !== 48'h0) begin
            errors++; $display("FAIL midreset_ops: A=%h B=%h C=%h want 0", opA, opB, opC);
        end
        do_fetch("after_reset", 16'h8123, 3'b000, 4'h2, 4'h3, 4'h1, 0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] list [3];
        logic [3:0]  exp_opc [3];
        logic [15:0] exp_a [3];
        int n_acc, n_hs, last;
        logic acc, hs;
        list    = '{16'h8123, 16'h2456, 16'h3789};
        exp_opc = '{4'h8, 4'h2, 4'h3};
        exp_a   = '{16'h1002, 16'h1005, 16'h1008};
        n_acc = 0; n_hs = 0; last = 0;
        {ReadRegSrc3, ReadRegSrc2, ReadRegSrc1} = 3'b000;
        instr = list[0]; instr_valid = 1'b1; op_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            acc = instr_ready && instr_valid;
            hs  = op_valid && op_ready;
            if (hs) begin
                checks++;
                if (n_hs >= 3 || op_opcode !== exp_opc[n_hs] || opA !== exp_a[n_hs]) begin
                    errors++;
                    $display("FAIL b2b_out%0d: opc=%h A=%h unexpected", n_hs, op_opcode, opA);
                end
                n_hs++;
            end
            step();
            if (acc) begin
                if (n_acc > 0) begin
                    checks++;
                    if (cyc - last !== 6) begin
                        errors++; $display("FAIL b2b_gap%0d: got %0d cycles want 6", n_acc, cyc - last);
                    end
                end
                last = cyc;
                n_acc++;
                if (n_acc < 3) instr = list[n_acc];
                else           instr_valid = 1'b0;
            end
        end
        op_ready = 1'b0;
        checks++;
        if (n_acc !== 3 || n_hs !== 3) begin
            errors++; $display("FAIL b2b_count: accepts=%0d outputs=%0d want 3 3", n_acc, n_hs);
        end
    endtask

`ifdef OPFETCH_WB_BYPASS_EN
    task automatic test_bypass();
        instr = 16'h8123; {ReadRegSrc3, ReadRegSrc2, ReadRegSrc1} = 3'b000;
        instr_valid = 1'b1; op_ready = 1'b0;
        step();
        instr_valid = 1'b0;
        step(); step();
        wb_en = 1'b1; wb_addr = 4'h3; wb_data = 16'hBEEF;
        step();
        wb_en = 1'b0; wb_addr = 4'h0; wb_data = 16'h0;
        step();
        checks++;
        if ({op_valid, opA, opB, opC} !== {1'b1, 16'h1002, 16'hBEEF, 16'h1001}) begin
            errors++;
            $display("FAIL bypass: val=%b A=%h B=%h C=%h want 1 1002 beef 1001", op_valid, opA, opB, opC);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_reset_midfetch();
        test_back_to_back();
`ifdef OPFETCH_WB_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
